// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the memory arbiter and the
// shared single-port RAM. The arbiter takes the slave view. The core and RAM
// side (in the bench, a core model and a RAM model) takes the master view.
interface riscv_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 12
);
   // instruction fetch port
   logic                  i_req;
   logic [31:0]           i_addr;
   logic                  i_ready;
   logic [31:0]           i_rdata;
   logic                  i_rvalid;
   // data load/store port
   logic                  d_read;
   logic                  d_write;
   logic [31:0]           d_addr;
   logic [1:0]            d_width;
   logic [31:0]           d_wdata;
   logic                  d_ready;
   logic [31:0]           d_rdata;
   logic                  d_rvalid;
   logic                  d_misaligned;
   // shared RAM port
   logic                  mem_en;
   logic                  mem_we;
   logic [3:0]            mem_be;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;

   modport slave (
      input  i_req, i_addr, d_read, d_write, d_addr, d_width, d_wdata, mem_rdata,
      output i_ready, i_rdata, i_rvalid, d_ready, d_rdata, d_rvalid, d_misaligned,
             mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_read, d_write, d_addr, d_width, d_wdata, mem_rdata,
      input  i_ready, i_rdata, i_rvalid, d_ready, d_rdata, d_rvalid, d_misaligned,
             mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port synchronous RAM (1-cycle read latency) between the
// instruction-fetch port and the data load/store port. Data wins by default.
// A bounded starvation counter hands the RAM to a waiting fetch after
// MAX_DATA_RUN consecutive data grants. Byte/half/word data accesses become
// word-addressed RAM cycles with byte enables, and load data is right-aligned.
module riscv_mem_arbiter #(
   parameter int ADDR_WIDTH   = 12,
   parameter int MAX_DATA_RUN = 4
) (
   input logic                clock,
   input logic                reset,
   riscv_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {RET_NONE = 2'd0, RET_FETCH = 2'd1, RET_DATA = 2'd2} ret_port_t;
   typedef enum logic {PORT_IDLE = 1'b0, PORT_RESP = 1'b1} port_state_t;

   localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

   // Width 3, odd halfwords and unaligned words are rejected.
   function automatic logic is_illegal(input logic [1:0] width, input logic [1:0] off);
      case (width)
         2'd0:    is_illegal = 1'b0;
         2'd1:    is_illegal = off[0];
         2'd2:    is_illegal = (off != 2'd0);
         default: is_illegal = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] width, input logic [1:0] off);
      case (width)
         2'd0:    store_be = 4'b0001 << off;
         2'd1:    store_be = 4'b0011 << off;
         default: store_be = 4'b1111;
      endcase
   endfunction

   // Store data is replicated across lanes so the byte enables pick the right copy.
   function automatic logic [31:0] store_data(input logic [1:0] width, input logic [31:0] wdata);
      case (width)
         2'd0:    store_data = {4{wdata[7:0]}};
         2'd1:    store_data = {2{wdata[15:0]}};
         default: store_data = wdata;
      endcase
   endfunction

   function automatic logic [31:0] load_align(input logic [31:0] raw, input logic [1:0] off,
                                              input logic [1:0] width);
      logic [31:0] shifted;
      shifted = raw >> {off, 3'b000};
      case (width)
         2'd0:    load_align = shifted & 32'h0000_00FF;
         2'd1:    load_align = shifted & 32'h0000_FFFF;
         default: load_align = shifted;
      endcase
   endfunction

   logic        d_req_s, d_load_s, d_illegal_s, d_grant_s, i_grant_s, fetch_wins_s, d_resp_s;
   logic [3:0]  starve_cnt_r, starve_cnt_next_s;
   ret_port_t   ret_port_r, ret_port_next_s;
   port_state_t i_state_r, i_state_next_s, d_state_r, d_state_next_s;
   logic [1:0]  ret_off_r, ret_w_r;
   logic        d_zero_r;
   logic [31:0] i_hold_r, d_hold_r, d_load_data_s;
   logic        unused_addr_bits_s;

   assign unused_addr_bits_s = ^{bus.i_addr[31:ADDR_WIDTH+2], bus.i_addr[1:0],
                                 bus.d_addr[31:ADDR_WIDTH+2]};

   // Arbitration: a legal data request wins unless a fetch has waited a full run.
   always_comb begin
      d_req_s      = bus.d_read | bus.d_write;
      d_load_s     = bus.d_read & ~bus.d_write;
      d_illegal_s  = d_req_s & is_illegal(bus.d_width, bus.d_addr[1:0]);
      fetch_wins_s = bus.i_req & (starve_cnt_r == MAX_RUN);
      d_grant_s    = d_req_s & ~d_illegal_s & ~fetch_wins_s;
      i_grant_s    = bus.i_req & ~d_grant_s;
      d_resp_s     = d_load_s & (d_grant_s | d_illegal_s);
   end

   // Starvation counter: counts data grants that made a fetch wait, saturating.
   always_comb begin
      starve_cnt_next_s = starve_cnt_r;
      if (i_grant_s || !bus.i_req) begin
         starve_cnt_next_s = 4'd0;
      end else if (d_grant_s && (starve_cnt_r != MAX_RUN)) begin
         starve_cnt_next_s = starve_cnt_r + 4'd1;
      end else begin
         starve_cnt_next_s = starve_cnt_r;
      end
   end

   // Port sequencing: a granted fetch or load always lands in RESP next cycle.
   always_comb begin
      i_state_next_s  = PORT_IDLE;
      d_state_next_s  = PORT_IDLE;
      ret_port_next_s = RET_NONE;
      case (i_state_r)
         PORT_IDLE: i_state_next_s = i_grant_s ? PORT_RESP : PORT_IDLE;
         PORT_RESP: i_state_next_s = i_grant_s ? PORT_RESP : PORT_IDLE;
         default:   i_state_next_s = PORT_IDLE;
      endcase
      case (d_state_r)
         PORT_IDLE: d_state_next_s = d_resp_s ? PORT_RESP : PORT_IDLE;
         PORT_RESP: d_state_next_s = d_resp_s ? PORT_RESP : PORT_IDLE;
         default:   d_state_next_s = PORT_IDLE;
      endcase
      if (i_grant_s) begin
         ret_port_next_s = RET_FETCH;
      end else if (d_grant_s && d_load_s) begin
         ret_port_next_s = RET_DATA;
      end else begin
         ret_port_next_s = RET_NONE;
      end
   end

   // State, return-path tags and held read data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt_r <= 4'd0;
         ret_port_r   <= RET_NONE;
         i_state_r    <= PORT_IDLE;
         d_state_r    <= PORT_IDLE;
         ret_off_r    <= 2'd0;
         ret_w_r      <= 2'd0;
         d_zero_r     <= 1'b0;
         i_hold_r     <= 32'd0;
         d_hold_r     <= 32'd0;
      end else begin
         starve_cnt_r <= starve_cnt_next_s;
         ret_port_r   <= ret_port_next_s;
         i_state_r    <= i_state_next_s;
         d_state_r    <= d_state_next_s;
         d_zero_r     <= d_illegal_s & d_load_s;
         if (d_grant_s) begin
            ret_off_r <= bus.d_addr[1:0];
            ret_w_r   <= bus.d_width;
         end else begin
            ret_off_r <= ret_off_r;
            ret_w_r   <= ret_w_r;
         end
         if (i_state_r == PORT_RESP) begin
            i_hold_r <= bus.mem_rdata;
         end else begin
            i_hold_r <= i_hold_r;
         end
         if (d_state_r == PORT_RESP) begin
            d_hold_r <= d_load_data_s;
         end else begin
            d_hold_r <= d_hold_r;
         end
      end
   end

   // Return path: route RAM data to its port, or replay the last value.
   always_comb begin
      d_load_data_s = 32'd0;
      if ((ret_port_r == RET_DATA) && !d_zero_r) begin
         d_load_data_s = load_align(bus.mem_rdata, ret_off_r, ret_w_r);
      end else begin
         d_load_data_s = 32'd0;
      end
      bus.i_rvalid = (i_state_r == PORT_RESP);
      bus.d_rvalid = (d_state_r == PORT_RESP);
      if (ret_port_r == RET_FETCH) begin
         bus.i_rdata = bus.mem_rdata;
      end else begin
         bus.i_rdata = i_hold_r;
      end
      if (d_state_r == PORT_RESP) begin
         bus.d_rdata = d_load_data_s;
      end else begin
         bus.d_rdata = d_hold_r;
      end
   end

   // RAM drive and handshakes; all strobes are held low while reset is high.
   always_comb begin
      bus.i_ready      = i_grant_s & ~reset;
      bus.d_ready      = (d_grant_s | d_illegal_s) & ~reset;
      bus.d_misaligned = d_illegal_s & ~reset;
      bus.mem_en       = (i_grant_s | d_grant_s) & ~reset;
      bus.mem_we       = d_grant_s & bus.d_write & ~reset;
      bus.mem_addr     = bus.i_addr[ADDR_WIDTH+1:2];
      bus.mem_be       = 4'b1111;
      bus.mem_wdata    = 32'd0;
      if (d_grant_s) begin
         bus.mem_addr = bus.d_addr[ADDR_WIDTH+1:2];
         if (bus.d_write) begin
            bus.mem_be    = store_be(bus.d_width, bus.d_addr[1:0]);
            bus.mem_wdata = store_data(bus.d_width, bus.d_wdata);
         end else begin
            bus.mem_be    = 4'b1111;
            bus.mem_wdata = 32'd0;
         end
      end else begin
         bus.mem_addr  = bus.i_addr[ADDR_WIDTH+1:2];
         bus.mem_be    = 4'b1111;
         bus.mem_wdata = 32'd0;
      end
   end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: a RAM model, a byte-level
// reference memory, and a response scoreboard fed at grant time.
module tb_riscv_mem_arbiter;
   localparam int AW = 12;

   logic clock = 1'b0;
   logic reset;
   logic init_ram;

   always #5 clock = ~clock;

   riscv_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

   riscv_mem_arbiter #(.ADDR_WIDTH(AW), .MAX_DATA_RUN(4)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   logic [31:0] ram     [0:4095];
   logic [31:0] ref_mem [0:4095];
   logic [31:0] iq[$];
   logic [31:0] dq[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] init_word(input int k);
      if (k == 4) return 32'h0050_0093;
      return 32'hA5A5_0000 ^ (32'(k) * 32'h0001_0203);
   endfunction

   // Shared RAM model: byte-enabled write, registered read.
   always @(posedge clock) begin
      if (init_ram) begin
         for (int k = 0; k < 4096; k++) ram[k] <= init_word(k);
      end else if (bus.mem_en) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_we && bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         bus.mem_rdata <= ram[bus.mem_addr];
      end
   end

   function automatic logic bench_illegal(input logic [1:0] w, input logic [31:0] a);
      return (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'd0);
   endfunction

   function automatic int nbytes(input logic [1:0] w);
      return (w == 2'd0) ? 1 : ((w == 2'd1) ? 2 : 4);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w);
      logic [31:0] r, ba;
      r = 32'd0;
      for (int k = 0; k < nbytes(w); k++) begin
         ba = a + 32'(k);
         r[8*k +: 8] = ref_mem[ba[13:2]][8*ba[1:0] +: 8];
      end
      return r;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] wd);
      logic [31:0] ba;
      for (int k = 0; k < nbytes(w); k++) begin
         ba = a + 32'(k);
         ref_mem[ba[13:2]][8*ba[1:0] +: 8] = wd[8*k +: 8];
      end
   endtask

   // Pops responses due this cycle, then queues responses for this cycle's grants.
   task automatic scoreboard();
      logic [31:0] exp;
      logic bad;
      if (!reset) begin
         if (bus.i_rvalid) begin
            checks++;
            if (iq.size() == 0) begin
               errors++; $display("FAIL i_rvalid_unexpected: got i_rvalid=1 expected 0");
            end else begin
               exp = iq.pop_front();
               if (bus.i_rdata !== exp) begin
                  errors++; $display("FAIL i_rdata_sb: got %h expected %h", bus.i_rdata, exp);
               end
            end
         end
         if (iq.size() != 0) begin
            checks++; errors++; iq.delete();
            $display("FAIL i_rvalid_missing: got i_rvalid=0 expected 1");
         end
         if (bus.d_rvalid) begin
            checks++;
            if (dq.size() == 0) begin
               errors++; $display("FAIL d_rvalid_unexpected: got d_rvalid=1 expected 0");
            end else begin
               exp = dq.pop_front();
               if (bus.d_rdata !== exp) begin
                  errors++; $display("FAIL d_rdata_sb: got %h expected %h", bus.d_rdata, exp);
               end
            end
         end
         if (dq.size() != 0) begin
            checks++; errors++; dq.delete();
            $display("FAIL d_rvalid_missing: got d_rvalid=0 expected 1");
         end
         if (bus.i_req && bus.i_ready) iq.push_back(ref_mem[bus.i_addr[13:2]]);
         if ((bus.d_read || bus.d_write) && bus.d_ready) begin
            bad = bench_illegal(bus.d_width, bus.d_addr);
            checks++;
            if (bus.d_misaligned !== bad) begin
               errors++; $display("FAIL d_misaligned_sb: got %b expected %b", bus.d_misaligned, bad);
            end
            if (bad) begin
               if (!bus.d_write) dq.push_back(32'd0);
            end else if (bus.d_write) begin
               ref_store(bus.d_addr, bus.d_width, bus.d_wdata);
            end else begin
               dq.push_back(ref_load(bus.d_addr, bus.d_width));
            end
         end
      end
   endtask

   task automatic sample();
      @(negedge clock);
      scoreboard();
   endtask

   task automatic advance();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.i_req = 1'b0; bus.i_addr = 32'd0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = 32'd0;
      bus.d_width = 2'd0; bus.d_wdata = 32'd0;
   endtask

   task automatic drive_d(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [1:0] w, input logic [31:0] wd);
      bus.d_read = rd; bus.d_write = wr; bus.d_addr = a; bus.d_width = w; bus.d_wdata = wd;
   endtask

   task automatic test_reset();
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      drive_d(1'b0, 1'b1, 32'h1, 2'd3, 32'hFFFF_FFFF);
      #1;
      checks++; if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready: got %b expected 0", bus.i_ready); end
      checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready: got %b expected 0", bus.d_ready); end
      checks++; if (bus.d_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", bus.d_misaligned); end
      checks++; if ({bus.mem_en, bus.mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_strobes: got %b expected 00", {bus.mem_en, bus.mem_we}); end
      checks++; if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", {bus.i_rvalid, bus.d_rvalid}); end
      checks++; if (bus.i_rdata !== 32'd0) begin errors++; $display("FAIL reset_i_rdata: got %h expected 0", bus.i_rdata); end
      checks++; if (bus.d_rdata !== 32'd0) begin errors++; $display("FAIL reset_d_rdata: got %h expected 0", bus.d_rdata); end
      idle();
   endtask

   task automatic test_fetch();
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      sample();
      checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready: got %b expected 1", bus.i_ready); end
      checks++; if ({bus.mem_en, bus.mem_we} !== 2'b10) begin errors++; $display("FAIL fetch_strobes: got %b expected 10", {bus.mem_en, bus.mem_we}); end
      checks++; if (bus.mem_addr !== 12'h004) begin errors++; $display("FAIL fetch_mem_addr: got %h expected 004", bus.mem_addr); end
      checks++; if (bus.mem_be !== 4'b1111) begin errors++; $display("FAIL fetch_mem_be: got %b expected 1111", bus.mem_be); end
      advance(); bus.i_req = 1'b0;
      sample();
      checks++; if (bus.i_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid: got %b expected 1", bus.i_rvalid); end
      checks++; if (bus.i_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_rdata: got %h expected 00500093", bus.i_rdata); end
      advance(); sample();
      checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_drop: got %b expected 0", bus.i_rvalid); end
      checks++; if (bus.i_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_rdata_hold: got %h expected 00500093", bus.i_rdata); end
      advance();
   endtask

   // Store then load of the same location; checks RAM drive and the aligned result.
   task automatic store_load(input string nm, input logic [31:0] a, input logic [1:0] w,
                             input logic [31:0] wd, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_load);
      drive_d(1'b0, 1'b1, a, w, wd);
      sample();
      checks++; if (bus.d_ready !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL %s_store_accept: got ready=%b we=%b expected 1 1", nm, bus.d_ready, bus.mem_we); end
      checks++; if (bus.mem_be !== exp_be) begin errors++; $display("FAIL %s_mem_be: got %b expected %b", nm, bus.mem_be, exp_be); end
      checks++; if (bus.mem_wdata !== exp_wdata) begin errors++; $display("FAIL %s_mem_wdata: got %h expected %h", nm, bus.mem_wdata, exp_wdata); end
      checks++; if (bus.mem_addr !== a[13:2]) begin errors++; $display("FAIL %s_mem_addr: got %h expected %h", nm, bus.mem_addr, a[13:2]); end
      advance(); drive_d(1'b1, 1'b0, a, w, 32'd0);
      sample();
      checks++; if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'b1111) begin errors++; $display("FAIL %s_load_drive: got we=%b be=%b expected 0 1111", nm, bus.mem_we, bus.mem_be); end
      advance(); idle();
      sample();
      checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== exp_load) begin errors++; $display("FAIL %s_load_data: got v=%b %h expected 1 %h", nm, bus.d_rvalid, bus.d_rdata, exp_load); end
      advance();
   endtask

   task automatic test_misaligned();
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      drive_d(1'b1, 1'b0, 32'h102, 2'd2, 32'd0);
      sample();
      checks++; if ({bus.d_ready, bus.d_misaligned} !== 2'b11) begin errors++; $display("FAIL mis_flags: got %b expected 11", {bus.d_ready, bus.d_misaligned}); end
      checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL mis_fetch_grant: got %b expected 1", bus.i_ready); end
      checks++; if (bus.mem_addr !== 12'h004 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL mis_mem: got addr=%h we=%b expected 004 0", bus.mem_addr, bus.mem_we); end
      advance(); idle();
      sample();
      checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'd0) begin errors++; $display("FAIL mis_rdata: got v=%b %h expected 1 0", bus.d_rvalid, bus.d_rdata); end
      checks++; if (bus.i_rvalid !== 1'b1) begin errors++; $display("FAIL mis_fetch_rvalid: got %b expected 1", bus.i_rvalid); end
      advance();
   endtask

   task automatic test_fetch_only();
      for (int k = 0; k < 4; k++) begin
         bus.i_req = 1'b1; bus.i_addr = 32'(4 * k);
         sample();
         checks++; if (bus.i_ready !== 1'b1 || bus.mem_en !== 1'b1) begin errors++; $display("FAIL fetch_only_%0d: got ready=%b en=%b expected 1 1", k, bus.i_ready, bus.mem_en); end
         advance();
      end
      idle(); sample(); advance();
   endtask

   task automatic test_starvation();
      logic exp_d;
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      drive_d(1'b1, 1'b0, 32'h20, 2'd2, 32'd0);
      for (int k = 0; k < 10; k++) begin
         sample();
         exp_d = ((k % 5) != 4);
         checks++; if (bus.d_ready !== exp_d || bus.i_ready !== !exp_d) begin errors++; $display("FAIL starve_grant_%0d: got d=%b i=%b expected d=%b i=%b", k, bus.d_ready, bus.i_ready, exp_d, !exp_d); end
         advance();
      end
      idle(); sample(); advance();
   endtask

   task automatic test_back_to_back();
      logic        t_wr   [0:5];
      logic [31:0] t_addr [0:5];
      logic [1:0]  t_w    [0:5];
      logic [31:0] t_wd   [0:5];
      logic [11:0] t_ma   [0:5];
      t_wr   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      t_addr = '{32'h20, 32'h23, 32'h30, 32'h30, 32'h4000_0010, 32'h32};
      t_w    = '{2'd2, 2'd0, 2'd2, 2'd2, 2'd2, 2'd1};
      t_wd   = '{32'd0, 32'd0, 32'hCAFE_F00D, 32'd0, 32'd0, 32'd0};
      t_ma   = '{12'h008, 12'h008, 12'h00C, 12'h00C, 12'h004, 12'h00C};
      for (int k = 0; k < 6; k++) begin
         drive_d(!t_wr[k], t_wr[k], t_addr[k], t_w[k], t_wd[k]);
         sample();
         checks++; if (bus.d_ready !== 1'b1 || bus.mem_addr !== t_ma[k]) begin errors++; $display("FAIL b2b_%0d: got ready=%b addr=%h expected 1 %h", k, bus.d_ready, bus.mem_addr, t_ma[k]); end
         if (k > 0 && !t_wr[k-1]) begin
            checks++; if (bus.d_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid_%0d: got %b expected 1", k, bus.d_rvalid); end
         end
         advance();
      end
      idle(); sample(); advance();
   endtask

   task automatic test_reset_mid();
      drive_d(1'b1, 1'b0, 32'h30, 2'd2, 32'd0);
      sample();
      checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL rstmid_grant: got %b expected 1", bus.d_ready); end
      advance();
      reset = 1'b1; iq.delete(); dq.delete();
      bus.i_req = 1'b1; bus.d_width = 2'd3; bus.d_addr = 32'h31;
      #1;
      checks++; if ({bus.i_ready, bus.d_ready, bus.d_misaligned, bus.mem_en, bus.mem_we} !== 5'b0) begin errors++; $display("FAIL rstmid_strobes: got %b expected 00000", {bus.i_ready, bus.d_ready, bus.d_misaligned, bus.mem_en, bus.mem_we}); end
      checks++; if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00 || bus.d_rdata !== 32'd0 || bus.i_rdata !== 32'd0) begin errors++; $display("FAIL rstmid_outputs: got v=%b d=%h i=%h expected 00 0 0", {bus.i_rvalid, bus.d_rvalid}, bus.d_rdata, bus.i_rdata); end
      advance(); idle(); reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample();
         checks++; if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin errors++; $display("FAIL rstmid_no_rvalid_%0d: got %b expected 00", k, {bus.i_rvalid, bus.d_rvalid}); end
         advance();
      end
      drive_d(1'b1, 1'b0, 32'h30, 2'd2, 32'd0);
      sample(); advance(); idle(); sample();
      checks++; if (bus.d_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rstmid_ram_kept: got %h expected cafef00d", bus.d_rdata); end
      advance();
   endtask

   task automatic test_random();
      logic dp, ip;
      int kind;
      dp = 1'b0; ip = 1'b0;
      for (int n = 0; n < 120; n++) begin
         if (!dp) begin
            if ($urandom_range(0, 3) != 0) begin
               kind = int'($urandom_range(0, 2));
               drive_d(kind != 1, kind != 0, ($urandom & 32'hC000_0000) | 32'($urandom_range(0, 63)),
                       2'($urandom_range(0, 3)), $urandom);
               dp = 1'b1;
            end else begin
               bus.d_read = 1'b0; bus.d_write = 1'b0;
            end
         end
         if (!ip) begin
            bus.i_req = ($urandom_range(0, 1) == 1);
            bus.i_addr = ($urandom & 32'hC000_0000) | 32'($urandom_range(0, 63));
            ip = bus.i_req;
         end
         sample();
         checks++; if ((ip || dp) && !(bus.i_ready || bus.d_ready)) begin errors++; $display("FAIL rand_no_grant_%0d: got i=%b d=%b expected a grant", n, bus.i_ready, bus.d_ready); end
         if (dp && bus.d_ready) dp = 1'b0;
         if (ip && bus.i_ready) ip = 1'b0;
         advance();
      end
      idle(); sample(); advance();
   endtask

   initial begin
      reset = 1'b1; init_ram = 1'b1;
      idle();
      for (int k = 0; k < 4096; k++) ref_mem[k] = init_word(k);
      advance();
      init_ram = 1'b0;
      test_reset();
      advance();
      reset = 1'b0;
      test_fetch();
      store_load("sb", 32'h103, 2'd0, 32'h1234_56AB, 4'b1000, 32'hABAB_ABAB, 32'h0000_00AB);
      store_load("sh", 32'h22, 2'd1, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h0000_BEEF);
      test_misaligned();
      test_fetch_only();
      test_starvation();
      test_back_to_back();
      test_reset_mid();
      test_random();
      checks++;
      if (iq.size() + dq.size() != 0) begin
         errors++; $display("FAIL drain: got %0d outstanding expected 0", iq.size() + dq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end
endmodule
